psg_bus_master: RTL

- Bus initiator that drives the BDIR/BC/data bus of the ym2149 PSG core on behalf of a CPU-side or sequencer-side register-access requester.
- Queues register write/read requests in a small FIFO and expands each into latch-address, write-value or read-value bus phases, separated by inactive gaps.
- Skips the latch-address phase when the target register is already latched in the PSG.
- Returns read data on a one-cycle response strobe.

---
 rtl/psg_bus_master.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/psg_bus_master.sv
// psg_bus_master: queues PSG register write/read requests and plays each one
// out on the YM2149 BDIR/BC/data bus as latch-address, write-value or
// read-value phases, each followed by an inactive gap. The latch phase is
// skipped when the PSG already holds the target address.
//
// Ports:
//   CLK, RESET             clock, synchronous active-high reset
//   REQ_VALID/REQ_READY    request handshake (REQ_READY = queue not full)
//   REQ_WRITE/ADDR/DATA    request payload (1 = write, 0 = read)
//   INVALIDATE             forget the cached PSG address
//   RSP_VALID/RSP_DATA     one-cycle read response strobe and held read data
//   BUSY                   queue non-empty or a transfer in progress
//   PSG_BDIR/BC/DO, PSG_DI PSG bus
module psg_bus_master #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WRITE,
  input  logic [7:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  input  logic       INVALIDATE,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BUSY,
  output logic       PSG_BDIR,
  output logic       PSG_BC,
  output logic [7:0] PSG_DO,
  input  logic [7:0] PSG_DI
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PH_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_GAP_A, S_XFER, S_GAP_X} state_t;

  state_t            r_state, w_state_nxt;
  logic [PH_W-1:0]   r_phase, w_phase_nxt;
  req_t              r_op, w_op_nxt;
  req_t              r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_ready;
  logic              r_cache_valid, w_cache_valid_nxt;
  logic [DATA_W-1:0] r_cache_addr, w_cache_addr_nxt;
  logic              r_bdir, r_bc, w_bdir_nxt, w_bc_nxt;
  logic [DATA_W-1:0] r_do, w_do_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_push, w_pop, w_hold_done, w_gap_done;
  req_t              w_req, w_head;

  assign REQ_READY = r_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_DATA  = r_rsp_data;
  assign BUSY      = r_busy;
  assign PSG_BDIR  = r_bdir;
  assign PSG_BC    = r_bc;
  assign PSG_DO    = r_do;

  assign w_req  = '{wr: REQ_WRITE, addr: REQ_ADDR, data: REQ_DATA};
  assign w_head = r_mem[r_rptr];
  // Readiness comes only from the registered count: a full queue never
  // accepts, even in a cycle where the head is popped.
  assign w_push = REQ_VALID & r_ready;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
  assign w_hold_done = (r_phase == PH_W'(HOLD_CYCLES - 1));
  assign w_gap_done  = (r_phase == PH_W'(GAP_CYCLES - 1));

  // Next-state, cache, response and bus decode.
  always_comb begin
    w_state_nxt       = r_state;
    w_phase_nxt       = r_phase;
    w_op_nxt          = r_op;
    w_cache_valid_nxt = r_cache_valid;
    w_cache_addr_nxt  = r_cache_addr;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_data_nxt    = r_rsp_data;
    w_bdir_nxt        = 1'b0;
    w_bc_nxt          = 1'b0;
    w_do_nxt          = '0;

    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_op_nxt    = w_head;
          w_phase_nxt = '0;
          if (!r_cache_valid || (r_cache_addr != w_head.addr)) w_state_nxt = S_LATCH;
          else                                                  w_state_nxt = S_XFER;
        end
      end
      S_LATCH: begin
        if (w_hold_done) begin
          w_state_nxt       = S_GAP_A;
          w_phase_nxt       = '0;
          w_cache_addr_nxt  = r_op.addr;
          w_cache_valid_nxt = 1'b1;
        end else begin
          w_phase_nxt = r_phase + PH_W'(1);
        end
      end
      S_GAP_A: begin
        if (w_gap_done) begin
          w_state_nxt = S_XFER;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + PH_W'(1);
        end
      end
      S_XFER: begin
        if (w_hold_done) begin
          w_state_nxt = S_GAP_X;
          w_phase_nxt = '0;
          // Read data is taken from the last cycle the PSG drives it.
          if (!r_op.wr) begin
            w_rsp_data_nxt  = PSG_DI;
            w_rsp_valid_nxt = 1'b1;
          end
        end else begin
          w_phase_nxt = r_phase + PH_W'(1);
        end
      end
      S_GAP_X: begin
        if (w_gap_done) begin
          w_state_nxt = S_IDLE;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + PH_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
      end
    endcase

    // Invalidate overrides a cache fill on the same edge.
    if (INVALIDATE) w_cache_valid_nxt = 1'b0;

    // Bus pins are registered copies of the decode of the next state.
    case (w_state_nxt)
      S_LATCH: begin
        w_bdir_nxt = 1'b1;
        w_bc_nxt   = 1'b1;
        w_do_nxt   = w_op_nxt.addr;
      end
      S_XFER: begin
        if (w_op_nxt.wr) begin
          w_bdir_nxt = 1'b1;
          w_do_nxt   = w_op_nxt.data;
        end else begin
          w_bc_nxt   = 1'b1;
        end
      end
      default: ;
    endcase

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase

    w_busy_nxt = (w_count_nxt != '0) || (w_state_nxt != S_IDLE);
  end

  // State, control and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_phase       <= '0;
      r_op          <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_ready       <= 1'b1;
      r_cache_valid <= 1'b0;
      r_cache_addr  <= '0;
      r_bdir        <= 1'b0;
      r_bc          <= 1'b0;
      r_do          <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_op          <= w_op_nxt;
      r_count       <= w_count_nxt;
      r_ready       <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
      r_cache_valid <= w_cache_valid_nxt;
      r_cache_addr  <= w_cache_addr_nxt;
      r_bdir        <= w_bdir_nxt;
      r_bc          <= w_bc_nxt;
      r_do          <= w_do_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_data    <= w_rsp_data_nxt;
      r_busy        <= w_busy_nxt;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= w_req;
  end

endmodule
